// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC bus sequencer: state encoding and the
// register sweep table.
package rtc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_WR,
        A_REL,
        D_RD,
        D_WR,
        D_REL
    } rtc_state_t;

    localparam int RTC_NUM_REGS = 11;
    localparam int RTC_IDX_W    = 4;

    localparam logic [7:0] RTC_ADDR_TABLE [0:RTC_NUM_REGS-1] = '{
        8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
        8'h41, 8'h42, 8'h43
    };

    localparam logic [7:0] RTC_LATCH_CMD = 8'hF0;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase; phase_end marks the last cycle
// of each T_PHASE-cycle phase while counting.
module rtc_phase_timer #(
    parameter int T_PHASE = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic phase_end
);

    localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(T_PHASE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= RELOAD;
        end else if (load || (cnt == '0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign phase_end = (cnt == '0) && !load;

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sweeps the external RTC's muxed AD bus and forwards each register byte to the
// bank with a one-cycle AoD=0 strobe. Define RTC_LATCH_CMD_EN to prefix every
// sweep with a latch-command write (0xF0).
//
// state | meaning
// IDLE  | bus released, period counter running
// A_WR  | address phase, write strobe low, AD driven
// A_REL | address held on AD, strobes released
// D_RD  | data phase, read strobe low, AD released
// D_WR  | data phase write of the latch command
// D_REL | strobes released; first cycle carries AoD=0 after a read
module rtc_bus_sequencer
    import rtc_pkg::*;
#(
    parameter int T_PHASE      = 10,
    parameter int SWEEP_PERIOD = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] rtc_ad_in,
    output logic [7:0] rtc_ad_out,
    output logic       rtc_ad_oe,
    output logic       rtc_cs_n,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n,
    output logic       rtc_a_d,
    output logic [7:0] address,
    output logic [7:0] data_vga,
    output logic       AoD,
    output logic       busy,
    output logic       done
);

`ifdef RTC_LATCH_CMD_EN
    localparam logic LATCH_EN = 1'b1;
`else
    localparam logic LATCH_EN = 1'b0;
`endif

    localparam int PW = (SWEEP_PERIOD > 1) ? $clog2(SWEEP_PERIOD) : 1;

    rtc_state_t           state, state_n;
    logic [RTC_IDX_W-1:0] idx, idx_n;
    logic                 latch, latch_n;
    logic                 done_n;
    logic [PW-1:0]        per_cnt;
    logic                 phase_end;
    logic                 sweep_start;
    logic [7:0]           tx_addr;

    rtc_phase_timer #(.T_PHASE(T_PHASE)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (state == IDLE),
        .phase_end (phase_end)
    );

    assign sweep_start = (state == IDLE) && (start || (per_cnt == PW'(SWEEP_PERIOD - 1)));
    assign tx_addr     = latch ? RTC_LATCH_CMD : RTC_ADDR_TABLE[idx];
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            latch    <= 1'b0;
            done     <= 1'b0;
            per_cnt  <= '0;
            address  <= 8'h00;
            data_vga <= 8'h00;
            AoD      <= 1'b1;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            latch   <= latch_n;
            done    <= done_n;
            per_cnt <= ((state == IDLE) && !sweep_start) ? per_cnt + PW'(1) : '0;
            AoD     <= 1'b1;
            // Byte and address land together so the bank sees both valid under AoD=0.
            if ((state == D_RD) && phase_end) begin
                data_vga <= rtc_ad_in;
                address  <= RTC_ADDR_TABLE[idx];
                AoD      <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        latch_n    = latch;
        done_n     = 1'b0;
        rtc_cs_n   = 1'b1;
        rtc_rd_n   = 1'b1;
        rtc_wr_n   = 1'b1;
        rtc_a_d    = 1'b1;
        rtc_ad_oe  = 1'b0;
        rtc_ad_out = 8'h00;
        case (state)
            IDLE: begin
                if (sweep_start) begin
                    state_n = A_WR;
                    idx_n   = '0;
                    latch_n = LATCH_EN;
                end
            end
            A_WR: begin
                rtc_cs_n   = 1'b0;
                rtc_a_d    = 1'b0;
                rtc_wr_n   = 1'b0;
                rtc_ad_oe  = 1'b1;
                rtc_ad_out = tx_addr;
                if (phase_end) state_n = A_REL;
            end
            A_REL: begin
                rtc_a_d    = 1'b0;
                rtc_ad_oe  = 1'b1;
                rtc_ad_out = tx_addr;
                if (phase_end) state_n = latch ? D_WR : D_RD;
            end
            D_RD: begin
                rtc_cs_n = 1'b0;
                rtc_rd_n = 1'b0;
                if (phase_end) state_n = D_REL;
            end
            D_WR: begin
                rtc_cs_n   = 1'b0;
                rtc_wr_n   = 1'b0;
                rtc_ad_oe  = 1'b1;
                rtc_ad_out = RTC_LATCH_CMD;
                if (phase_end) state_n = D_REL;
            end
            D_REL: begin
                if (phase_end) begin
                    if (latch) begin
                        latch_n = 1'b0;
                        state_n = A_WR;
                    end else if (idx == RTC_IDX_W'(RTC_NUM_REGS - 1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n   = idx + RTC_IDX_W'(1);
                        state_n = A_WR;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: expected (address, byte) pairs are
// queued per sweep and a negedge monitor checks each AoD strobe and sweep end.
module tb_rtc_bus_sequencer;

`ifdef RTC_LATCH_CMD_EN
    localparam int SWEEP_LEN = 96;
    localparam int EXP_WD    = 2;
`else
    localparam int SWEEP_LEN = 88;
    localparam int EXP_WD    = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] rtc_ad_in, rtc_ad_out, address, data_vga;
    logic       rtc_ad_oe, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_a_d, AoD, busy, done;

    rtc_bus_sequencer #(.T_PHASE(2), .SWEEP_PERIOD(500)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .rtc_ad_in  (rtc_ad_in),
        .rtc_ad_out (rtc_ad_out),
        .rtc_ad_oe  (rtc_ad_oe),
        .rtc_cs_n   (rtc_cs_n),
        .rtc_rd_n   (rtc_rd_n),
        .rtc_wr_n   (rtc_wr_n),
        .rtc_a_d    (rtc_a_d),
        .address    (address),
        .data_vga   (data_vga),
        .AoD        (AoD),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // RTC model: latches the address phase and answers ~addr, optionally scrambled.
    logic [7:0] rtc_addr_m = 8'h00;
    logic [7:0] rtc_mask   = 8'h00;
    always @(posedge clk)
        if (!rtc_cs_n && !rtc_a_d && !rtc_wr_n && rtc_ad_oe) rtc_addr_m <= rtc_ad_out;
    assign rtc_ad_in = ~rtc_addr_m ^ rtc_mask;

    logic [7:0]  tbl [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
                              8'h41, 8'h42, 8'h43};
    logic [15:0] q [$];
    int compared = 0, mismatched = 0;
    int pushed = 0, strobes_seen = 0, exp_dones = 0, dones = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_sweep();
        logic [7:0] a;
        for (int i = 0; i < 11; i++) begin
            a = tbl[i];
            q.push_back({a, 8'(~a ^ rtc_mask)});
        end
        pushed += 11;
        exp_dones++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, int'(seen), 1);
    endtask

    // Monitor
    logic       prev_aod = 1'b1, prev_cs = 1'b1, prev_ad = 1'b1;
    int         busy_cnt = 0, sweep_strobes = 0, viol = 0, wdata = 0;
    logic [15:0] e;
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cnt = 0; sweep_strobes = 0; viol = 0; wdata = 0;
            prev_aod = 1'b1; prev_cs = 1'b1; prev_ad = 1'b1;
        end else begin
            if (rtc_ad_oe && !rtc_rd_n) viol++;
            if (!prev_cs && !rtc_cs_n && (prev_ad != rtc_a_d)) viol++;
            if (!AoD && !prev_aod) viol++;
            if (!rtc_wr_n && rtc_a_d && !rtc_cs_n) begin
                wdata++;
                if (!rtc_ad_oe || rtc_ad_out != 8'hF0) viol++;
            end
            if (busy) busy_cnt++;
            if (!AoD) begin
                strobes_seen++;
                sweep_strobes++;
                if (q.size() == 0) begin
                    check("unexpected strobe", int'(address), -1);
                end else begin
                    e = q.pop_front();
                    check("strobe address", int'(address), int'(e[15:8]));
                    check("strobe data", int'(data_vga), int'(e[7:0]));
                end
            end
            if (done) begin
                dones++;
                check("sweep length", busy_cnt, SWEEP_LEN);
                check("busy at done", int'(busy), 0);
                check("strobes per sweep", sweep_strobes, 11);
                check("bus violations", viol, 0);
                check("write-data cycles", wdata, EXP_WD);
                busy_cnt = 0; sweep_strobes = 0; viol = 0; wdata = 0;
            end
            prev_aod = AoD;
            prev_cs  = rtc_cs_n;
            prev_ad  = rtc_a_d;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, gap, extra, busy_cycles, flushed;
        bit found;
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset cs_n", int'(rtc_cs_n), 1);
        check("reset rd_n", int'(rtc_rd_n), 1);
        check("reset wr_n", int'(rtc_wr_n), 1);
        check("reset a_d", int'(rtc_a_d), 1);
        check("reset ad_oe", int'(rtc_ad_oe), 0);
        check("reset ad_out", int'(rtc_ad_out), 0);
        check("reset address", int'(address), 0);
        check("reset data_vga", int'(data_vga), 0);
        check("reset AoD", int'(AoD), 1);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);

        // Auto sweep after SWEEP_PERIOD idle cycles
        push_sweep();
        reset_n = 1'b1;
        n = 0;
        while (n < 600) begin
            @(posedge clk); #1;
            n++;
            if (busy) break;
        end
        check("auto sweep delay", n, 500);
        wait_done("auto sweep done", 200);

        // Manual start with ignored re-pulses during the sweep
        repeat (3) @(posedge clk);
        #1;
        rtc_mask = 8'h00;
        push_sweep();
        pulse_start();
        repeat (19) @(posedge clk);
        #1;
        pulse_start();
        repeat (39) @(posedge clk);
        #1;
        pulse_start();
        wait_done("restart sweep done", 200);
        busy_cycles = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (busy) busy_cycles++;
        end
        check("no second sweep", busy_cycles, 0);

        // Random sweeps with random data and stray starts
        repeat (5) begin
            gap = $urandom_range(1, 50);
            repeat (gap) @(posedge clk);
            #1;
            rtc_mask = 8'($urandom);
            push_sweep();
            pulse_start();
            extra = $urandom_range(1, 80);
            repeat (extra) @(posedge clk);
            #1;
            pulse_start();
            wait_done("random sweep done", 200);
        end

        // Reset during the data read of 0x25
        repeat (5) @(posedge clk);
        #1;
        rtc_mask = 8'h00;
        push_sweep();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!rtc_rd_n && rtc_addr_m == 8'h25) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("reached read of 0x25", int'(found), 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("abort cs_n", int'(rtc_cs_n), 1);
        check("abort rd_n", int'(rtc_rd_n), 1);
        check("abort wr_n", int'(rtc_wr_n), 1);
        check("abort ad_oe", int'(rtc_ad_oe), 0);
        check("abort AoD", int'(AoD), 1);
        check("abort busy", int'(busy), 0);
        flushed = q.size();
        check("strobes left at abort", flushed, 7);
        pushed -= flushed;
        exp_dones--;
        q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rtc_mask = 8'($urandom);
        push_sweep();
        pulse_start();
        wait_done("post-abort sweep done", 200);

        repeat (20) @(posedge clk);
        #1;
        check("queue drained", q.size(), 0);
        check("total strobes", strobes_seen, pushed);
        check("total dones", dones, exp_dones);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
